// File: rtl/mdc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mdc_pkg : command codes, sequencer states and decode helpers               |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package mdc_pkg;

  typedef logic [2:0] cmd_t;

  localparam cmd_t CMD_NADA          = 3'b000;
  localparam cmd_t CMD_SERVIR_CAFE   = 3'b001;
  localparam cmd_t CMD_SERVIR_BEBIDA = 3'b010;
  localparam cmd_t CMD_DEVOLVER      = 3'b100;
  localparam cmd_t CMD_CAFE_Y_CAMBIO = 3'b111;

  // One bit per code: set where the code is a legal command (000 included).
  localparam logic [7:0] C_CMD_VALIDO = 8'b1001_0111;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_MOLER  = 3'd1,
    ST_AGUA   = 3'd2,
    ST_BEBIDA = 3'd3,
    ST_MONEDA = 3'd4,
    ST_FIN    = 3'd5
  } desp_state_t;

  function automatic logic cmd_invalido(input cmd_t c);
    return !C_CMD_VALIDO[c];
  endfunction

  function automatic logic usa_agua(input cmd_t c);
    return (c == CMD_SERVIR_CAFE) || (c == CMD_CAFE_Y_CAMBIO);
  endfunction

  function automatic desp_state_t primera_fase(input cmd_t c);
    case (c)
      CMD_SERVIR_CAFE, CMD_CAFE_Y_CAMBIO: return ST_MOLER;
      CMD_SERVIR_BEBIDA:                  return ST_BEBIDA;
      CMD_DEVOLVER:                       return ST_MONEDA;
      default:                            return ST_IDLE;
    endcase
  endfunction

  function automatic desp_state_t fase_siguiente(input desp_state_t s, input cmd_t c);
    case (s)
      ST_MOLER: return ST_AGUA;
      ST_AGUA:  return (c == CMD_CAFE_Y_CAMBIO) ? ST_MONEDA : ST_FIN;
      ST_BEBIDA,
      ST_MONEDA: return ST_FIN;
      default:  return ST_IDLE;
    endcase
  endfunction

  function automatic logic fase_activa(input desp_state_t s);
    return (s == ST_MOLER) || (s == ST_AGUA) || (s == ST_BEBIDA) || (s == ST_MONEDA);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdc_despachador_temporizador.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mdc_temporizador : loadable down-counter with zero flag, no wrap           |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module mdc_temporizador #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] valor,
  input  logic          en,
  output logic          cero
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = valor;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cero = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/mdc_despachador.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mdc_despachador : timed actuator sequencer for the coffee-machine FSM      |
// | Optional water interlock: define MDC_INTERLOCK_AGUA_EN. Rev 1.0            |
// +----------------------------------------------------------------------------+
module mdc_despachador
  import mdc_pkg::*;
#(
  parameter int T_MOLER  = 4,
  parameter int T_AGUA   = 8,
  parameter int T_BEBIDA = 6,
  parameter int T_MONEDA = 2,
  parameter int CW       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] cmd,
`ifdef MDC_INTERLOCK_AGUA_EN
  input  logic       ha,
`endif
  output logic       molino,
  output logic       valvula,
  output logic       bebida,
  output logic       moneda,
  output logic       ocupado,
  output logic       listo,
  output logic       error
);

  desp_state_t   state_q, state_d;
  cmd_t          cmd_q, cmd_d;
  logic          armado_q, armado_d;
  logic          error_d;
  logic          molino_q, valvula_q, bebida_q, moneda_q, ocupado_q, listo_q, error_q;
  logic          acepta;
  logic          agua_ok;
  logic          carga;
  logic          cuenta_en;
  logic          cero;
  logic [CW-1:0] carga_valor;

`ifdef MDC_INTERLOCK_AGUA_EN
  assign agua_ok = ha;
`else
  assign agua_ok = 1'b1;
`endif

  function automatic logic [CW-1:0] duracion(input desp_state_t s);
    case (s)
      ST_MOLER:  return CW'(T_MOLER - 1);
      ST_AGUA:   return CW'(T_AGUA - 1);
      ST_BEBIDA: return CW'(T_BEBIDA - 1);
      ST_MONEDA: return CW'(T_MONEDA - 1);
      default:   return '0;
    endcase
  endfunction

  assign acepta = (state_q == ST_IDLE) && armado_q && (cmd != CMD_NADA);

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    armado_d = armado_q;
    error_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (acepta) begin
          if (cmd_invalido(cmd)) begin
            error_d = 1'b1;
          end else begin
            cmd_d = cmd;
            // A coffee request without water goes straight to the refund.
            if (usa_agua(cmd) && !agua_ok) begin
              state_d = ST_MONEDA;
            end else begin
              state_d = primera_fase(cmd);
            end
          end
        end
      end
      ST_MOLER, ST_AGUA: begin
        if (!agua_ok) begin
          state_d = ST_MONEDA;
          error_d = 1'b1;
        end else if (cero) begin
          state_d = fase_siguiente(state_q, cmd_q);
        end
      end
      ST_BEBIDA, ST_MONEDA: begin
        if (cero) begin
          state_d = fase_siguiente(state_q, cmd_q);
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (cmd == CMD_NADA) begin
      armado_d = 1'b1;
    end else if (acepta) begin
      armado_d = 1'b0;
    end
  end

  // Every phase entry reloads the shared timer with that phase's length minus one.
  assign carga       = (state_d != state_q) && fase_activa(state_d);
  assign carga_valor = duracion(state_d);
  assign cuenta_en   = fase_activa(state_q);

  mdc_temporizador #(
    .CW (CW)
  ) u_temporizador (
    .clk   (clk),
    .rst   (rst),
    .load  (carga),
    .valor (carga_valor),
    .en    (cuenta_en),
    .cero  (cero)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cmd_q     <= CMD_NADA;
      armado_q  <= 1'b1;
      molino_q  <= 1'b0;
      valvula_q <= 1'b0;
      bebida_q  <= 1'b0;
      moneda_q  <= 1'b0;
      ocupado_q <= 1'b0;
      listo_q   <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      armado_q  <= armado_d;
      molino_q  <= (state_d == ST_MOLER);
      valvula_q <= (state_d == ST_AGUA);
      bebida_q  <= (state_d == ST_BEBIDA);
      moneda_q  <= (state_d == ST_MONEDA);
      ocupado_q <= (state_d != ST_IDLE);
      listo_q   <= (state_d == ST_FIN);
      error_q   <= error_d;
    end
  end

  assign molino  = molino_q;
  assign valvula = valvula_q;
  assign bebida  = bebida_q;
  assign moneda  = moneda_q;
  assign ocupado = ocupado_q;
  assign listo   = listo_q;
  assign error   = error_q;

endmodule
`default_nettype wire

// File: tb/tb_mdc_despachador.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mdc_despachador : self-checking bench with queue-based output model     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_mdc_despachador;

  localparam int T_MOLER  = 4;
  localparam int T_AGUA   = 8;
  localparam int T_BEBIDA = 6;
  localparam int T_MONEDA = 2;

  // Output word layout: {molino, valvula, bebida, moneda, ocupado, listo, error}
  localparam logic [6:0] W_MOL = 7'b1000100;
  localparam logic [6:0] W_AGU = 7'b0100100;
  localparam logic [6:0] W_BEB = 7'b0010100;
  localparam logic [6:0] W_MON = 7'b0001100;
  localparam logic [6:0] W_FIN = 7'b0000110;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] cmd = 3'b000;
  logic       ha  = 1'b1;
  logic       molino, valvula, bebida, moneda, ocupado, listo, error;
  logic [6:0] dut_w;

  int n_cmp = 0;
  int n_bad = 0;
  int cnt [7];

  logic [6:0] exp_w = '0;
  logic [6:0] q[$];
  logic       arm = 1'b1;

  always #5 clk = ~clk;

  mdc_despachador #(
    .T_MOLER  (T_MOLER),
    .T_AGUA   (T_AGUA),
    .T_BEBIDA (T_BEBIDA),
    .T_MONEDA (T_MONEDA),
    .CW       (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .cmd     (cmd),
`ifdef MDC_INTERLOCK_AGUA_EN
    .ha      (ha),
`endif
    .molino  (molino),
    .valvula (valvula),
    .bebida  (bebida),
    .moneda  (moneda),
    .ocupado (ocupado),
    .listo   (listo),
    .error   (error)
  );

  assign dut_w = {molino, valvula, bebida, moneda, ocupado, listo, error};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic push_n(input logic [6:0] w, input int n);
    for (int i = 0; i < n; i++) q.push_back(w);
  endtask

  task automatic clr_counts();
    for (int b = 0; b < 7; b++) cnt[b] = 0;
  endtask

  // Reference model: an accepted command expands into its per-cycle output words.
  initial begin : model
    logic err, acc;
    forever begin
      @(posedge clk);
      if (!rst) begin
        q.delete();
        exp_w = '0;
        arm   = 1'b1;
      end else begin
        err = 1'b0;
        if (!ha && (exp_w[6] || exp_w[5])) begin
          q.delete();
          push_n(W_MON, T_MONEDA);
          q.push_back(W_FIN);
          err = 1'b1;
        end
        acc = !exp_w[2] && arm && (cmd != 3'b000);
        if (acc) begin
          if ((cmd == 3'b001 || cmd == 3'b111) && !ha) begin
            push_n(W_MON, T_MONEDA);
            q.push_back(W_FIN);
          end else begin
            case (cmd)
              3'b001: begin push_n(W_MOL, T_MOLER); push_n(W_AGU, T_AGUA); q.push_back(W_FIN); end
              3'b111: begin
                push_n(W_MOL, T_MOLER); push_n(W_AGU, T_AGUA); push_n(W_MON, T_MONEDA);
                q.push_back(W_FIN);
              end
              3'b010: begin push_n(W_BEB, T_BEBIDA); q.push_back(W_FIN); end
              3'b100: begin push_n(W_MON, T_MONEDA); q.push_back(W_FIN); end
              default: err = 1'b1;
            endcase
          end
        end
        if (cmd == 3'b000) arm = 1'b1;
        else if (acc) arm = 1'b0;
        exp_w = (q.size() > 0) ? q.pop_front() : 7'b0;
        exp_w[0] = err;
      end
    end
  end

  initial begin : monitor
    forever begin
      @(posedge clk);
      #2;
      chk("outputs", {25'b0, dut_w}, {25'b0, exp_w});
      for (int b = 0; b < 7; b++) if (dut_w[b] === 1'b1) cnt[b]++;
    end
  end

  task automatic wait_high(input int bit_idx, input int budget, input string nm);
    int k;
    k = 0;
    while (dut_w[bit_idx] !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (dut_w[bit_idx] !== 1'b1) chk({nm, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int r;
    clr_counts();
    // Reset held with a valid command present.
    rst = 1'b0;
    cmd = 3'b001;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {25'b0, dut_w}, 32'd0);
    clr_counts();
    rst = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 1)  chk("cafe_molino_c1", molino, 1);
      if (k == 4)  chk("cafe_molino_c4", molino, 1);
      if (k == 5)  chk("cafe_valvula_c5", {valvula, molino}, 2'b10);
      if (k == 12) chk("cafe_valvula_c12", valvula, 1);
      if (k == 13) chk("cafe_listo_c13", {listo, valvula, ocupado}, 3'b101);
      if (k == 14) chk("cafe_ocupado_c14", {ocupado, listo}, 2'b00);
    end
    chk("cafe_molino_len", cnt[6], T_MOLER);
    chk("cafe_valvula_len", cnt[5], T_AGUA);

    // CAFE_Y_CAMBIO held long: one sequence only.
    cmd = 3'b000;
    repeat (2) @(negedge clk);
    clr_counts();
    cmd = 3'b111;
    repeat (30) @(negedge clk);
    chk("cyc_molino_len", cnt[6], 4);
    chk("cyc_valvula_len", cnt[5], 8);
    chk("cyc_moneda_len", cnt[3], 2);
    chk("cyc_listo_cnt", cnt[1], 1);
    chk("cyc_ocupado_len", cnt[2], 15);
    cmd = 3'b000;
    repeat (2) @(negedge clk);
    clr_counts();
    cmd = 3'b010;
    repeat (10) @(negedge clk);
    chk("bebida_len", cnt[4], 6);
    chk("bebida_listo", cnt[1], 1);

    // Invalid code, then refund.
    cmd = 3'b000;
    repeat (2) @(negedge clk);
    clr_counts();
    cmd = 3'b011;
    repeat (4) @(negedge clk);
    chk("inval_error_cnt", cnt[0], 1);
    chk("inval_ocupado_cnt", cnt[2], 0);
    cmd = 3'b000;
    @(negedge clk);
    clr_counts();
    cmd = 3'b100;
    repeat (5) @(negedge clk);
    chk("devolver_moneda_len", cnt[3], 2);
    chk("devolver_listo", cnt[1], 1);

    // Command change during AGUA is ignored.
    cmd = 3'b000;
    repeat (2) @(negedge clk);
    clr_counts();
    cmd = 3'b001;
    wait_high(5, 20, "agua_start");
    cmd = 3'b010;
    repeat (12) @(negedge clk);
    chk("ignore_bebida_cnt", cnt[4], 0);
    chk("ignore_valvula_len", cnt[5], 8);
    chk("ignore_listo", cnt[1], 1);

    // Reset during the third valvula cycle.
    cmd = 3'b000;
    repeat (2) @(negedge clk);
    cmd = 3'b001;
    wait_high(5, 20, "agua_start2");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midreset_outputs", {25'b0, dut_w}, 32'd0);
    cmd = 3'b000;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    clr_counts();
    cmd = 3'b001;
    repeat (16) @(negedge clk);
    chk("post_reset_molino", cnt[6], 4);
    chk("post_reset_valvula", cnt[5], 8);
    chk("post_reset_listo", cnt[1], 1);

`ifdef MDC_INTERLOCK_AGUA_EN
    cmd = 3'b000;
    repeat (2) @(negedge clk);
    clr_counts();
    cmd = 3'b001;
    wait_high(5, 20, "agua_start3");
    @(negedge clk);
    ha = 1'b0;
    @(negedge clk);
    chk("abort_edge", {valvula, moneda, error}, 3'b011);
    ha = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort_valvula_len", cnt[5], 2);
    chk("abort_moneda_len", cnt[3], 2);
    chk("abort_listo", cnt[1], 1);
    chk("abort_error_cnt", cnt[0], 1);
`endif

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      r = $urandom_range(0, 9);
      if (r >= 4 && r <= 6) cmd = 3'b000;
      else if (r >= 7) cmd = 3'($urandom_range(0, 7));
      rst = ($urandom_range(0, 79) != 0);
`ifdef MDC_INTERLOCK_AGUA_EN
      ha = ($urandom_range(0, 19) != 0);
`endif
    end
    @(negedge clk);
    rst = 1'b1;
    cmd = 3'b000;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mdc_despachador.md
Name: mdc_despachador

Overview:
- Actuator sequencer on the output side of the coffee-machine FSM.
- Receives the FSM's 3-bit `out` command and drives the physical actuators with fixed, parameterised timing: grinder, water valve, drink dispenser and coin return.
- Reports busy, done and error status back to the FSM and the front panel.
- Holds one command at a time and re-arms only after the command bus returns to idle (000).

Parameters:
- T_MOLER, 4, grinder-on duration in clk cycles (≥1)
- T_AGUA, 8, water-valve-open duration in cycles (≥1)
- T_BEBIDA, 6, drink-dispenser-on duration in cycles (≥1)
- T_MONEDA, 2, coin-return solenoid duration in cycles (≥1)
- CW, 8, phase-counter width; every T_* must be ≤ 2^CW

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-low reset; block is in reset while rst=0 at a rising edge
- cmd  in  3  command from the FSM `out` bus
- molino  out  1  grinder enable
- valvula  out  1  water-valve enable
- bebida  out  1  drink-dispenser enable
- moneda  out  1  coin-return solenoid
- ocupado  out  1  high while a sequence is executing
- listo  out  1  one-cycle pulse when a sequence completes
- error  out  1  one-cycle pulse when an invalid command is rejected
- ha  in  1  water-present sensor; exists only with MDC_INTERLOCK_AGUA_EN

Behaviour:
- Command codes (from the package):
  - 000 NADA
  - 001 SERVIR_CAFE
  - 010 SERVIR_BEBIDA
  - 100 DEVOLVER
  - 111 CAFE_Y_CAMBIO
  - 011, 101 and 110 are invalid.
- All outputs are registered. Reset value is 0 for every output, state=IDLE, counter=0, armado=1.
- States: IDLE, MOLER, AGUA, BEBIDA, MONEDA, FIN.
- Accept rule: at a rising edge with state=IDLE, armado=1 and cmd≠000, the command is latched and armado clears.
- First phase for each accepted command:
  - SERVIR_CAFE and CAFE_Y_CAMBIO → MOLER
  - SERVIR_BEBIDA → BEBIDA
  - DEVOLVER → MONEDA
  - invalid code → stays in IDLE, error=1 for exactly one cycle.
- The phase's actuator is high starting the cycle after the accept edge. Latency from the cmd-sampled edge to the actuator high is 1 cycle.
- Phase length: each phase asserts its actuator for exactly T_* cycles. The counter loads T_*−1 on entry and advances the state when it reaches 0. Exactly one actuator is high at any time.
- Phase sequences:
  - SERVIR_CAFE: MOLER → AGUA → FIN
  - CAFE_Y_CAMBIO: MOLER → AGUA → MONEDA → FIN
  - SERVIR_BEBIDA: BEBIDA → FIN
  - DEVOLVER: MONEDA → FIN
- Transitions are back-to-back with no idle cycle between phases.
- FIN lasts 1 cycle with listo=1 and all actuators 0, then goes to IDLE.
- ocupado is high in MOLER, AGUA, BEBIDA, MONEDA and FIN.
- Re-arm: armado sets at any edge where cmd=000. A command held constant after completion does not retrigger.
- cmd changes during a sequence are ignored. They are neither queued nor errored, except that cmd=000 still re-arms.
- Reset mid-sequence: all actuators drop on the same reset edge and the in-flight command is discarded.
- No counter wrap: the counter only decrements from its loaded value to 0.

Optional Feature:
- MDC_INTERLOCK_AGUA_EN, when defined:
  - Adds the `ha` input.
  - If ha=0 is sampled in MOLER or AGUA, the next state is MONEDA (refund of T_MONEDA cycles), then FIN.
  - error pulses on the abort edge; listo still pulses in FIN.
  - A SERVIR_CAFE or CAFE_Y_CAMBIO accepted while ha=0 goes directly to MONEDA.
- When undefined: no `ha` port, and sequences ignore water status.

Decomposition:
- Package mdc_pkg holds:
  - the command code localparams/typedef (cmd_t);
  - the state enum (desp_state_t);
  - a helper constant for invalid-code detection.
- Sub-module mdc_temporizador: a loadable down-counter.
  - Inputs: load, load value, enable.
  - Output: zero flag.
  - Instantiated once and shared by all phases.

Test Plan:
- Reset with cmd=001 held and rst=0 → all outputs 0, no accept. Release rst → molino high for cycles 1–4, valvula for 5–12, listo pulse at cycle 13, ocupado low from 14.
- cmd=111 → molino 4 cycles, valvula 8 cycles, moneda 2 cycles, listo 1 cycle. Hold cmd=111 for 30 cycles → no second sequence. Drive 000 then 010 → bebida 6 cycles.
- cmd=011 → error pulse of exactly 1 cycle, no actuator and no ocupado. Then 000→100 → moneda 2 cycles, listo.
- cmd switches 001→010 during AGUA → the coffee sequence completes unchanged and bebida never asserts.
- Drive rst=0 at the 3rd valvula cycle → all outputs 0 at the next edge. After release with cmd=000→001 → a fresh full sequence.
- MDC_INTERLOCK_AGUA_EN: ha drops during the 2nd valvula cycle → valvula falls, moneda 2 cycles, error pulse on the abort edge, then listo.
